dual_slope_seq: RTL and testbench

DUAL_SLOPE_SEQ -- requirements
Module: dual_slope_seq

---
 rtl/dual_slope_seq.sv | 170 +++++++++++++++++
 tb/tb_dual_slope_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_seq.sv
// Dual-slope ADC conversion sequencer: steps the analog front end through
// reset, auto-zero, fixed integrate and counted deintegrate, then reports the count.
module dual_slope_seq #(
   parameter int RST_CYCLES = 4,
   parameter int AZ_CYCLES  = 1000,
   parameter int INT_CYCLES = 1000,
   parameter int DEINT_MAX  = 2000,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [2:0]       range_sel_i,
   input  logic             comp_i,
   input  logic             sat_hi_i,
   input  logic             sat_lo_i,
   input  logic             ref_ok_i,
   output logic [1:0]       afe_sel_o,
   output logic [2:0]       range_sel_o,
   output logic             afe_reset_o,
   output logic             ref_sign_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] result_o,
   output logic             polarity_o,
   output logic             overrange_o
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WAIT_REF = 3'd1;
   localparam logic [2:0] RST      = 3'd2;
   localparam logic [2:0] AZ       = 3'd3;
   localparam logic [2:0] INT      = 3'd4;
   localparam logic [2:0] DEINT    = 3'd5;
   localparam logic [2:0] DONE     = 3'd6;

   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] AZ_LAST    = CNT_W'(AZ_CYCLES - 1);
   localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(INT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEINT_LAST = CNT_W'(DEINT_MAX - 1);
   localparam logic [CNT_W-1:0] DEINT_OVR  = CNT_W'(DEINT_MAX);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             pol;

   // Bit order in both synchronizer stages: {ref_ok, sat_lo, sat_hi, comp}.
   logic [3:0] meta;
   logic [3:0] sync;
   logic       comp_s, sat_hi_s, sat_lo_s, ref_ok_s;

   // NOTE: every flop below uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {ref_ok_i, sat_lo_i, sat_hi_i, comp_i};
         sync <= meta;
      end
   end

   assign {ref_ok_s, sat_lo_s, sat_hi_s, comp_s} = sync;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         pol         <= 1'b0;
         range_sel_o <= '0;
         result_o    <= '0;
         polarity_o  <= 1'b0;
         overrange_o <= 1'b0;
      end else if (abort_i && state != IDLE) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (start_i && !abort_i) begin
                  state       <= WAIT_REF;
                  range_sel_o <= range_sel_i;
               end
            end
            WAIT_REF: begin
               cnt <= '0;
               if (ref_ok_s) state <= RST;
            end
            RST: begin
               if (cnt == RST_LAST) begin
                  state <= AZ;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            AZ: begin
               if (cnt == AZ_LAST) begin
                  state <= INT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            INT: begin
               // A saturated integrator makes the deintegrate count meaningless.
               if (sat_hi_s || sat_lo_s) begin
                  state       <= DONE;
                  cnt         <= '0;
                  result_o    <= '0;
                  overrange_o <= 1'b1;
                  polarity_o  <= sat_hi_s;
               end else if (cnt == INT_LAST) begin
                  state <= DEINT;
                  cnt   <= '0;
                  pol   <= comp_s;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DEINT: begin
               if (comp_s != pol) begin
                  state       <= DONE;
                  cnt         <= '0;
                  result_o    <= cnt;
                  overrange_o <= 1'b0;
                  polarity_o  <= pol;
               end else if (cnt == DEINT_LAST) begin
                  state       <= DONE;
                  cnt         <= '0;
                  result_o    <= DEINT_OVR;
                  overrange_o <= 1'b1;
                  polarity_o  <= pol;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // NOTE: defaults first so no path through the case leaves an output unassigned.
   always_comb begin
      afe_sel_o   = 2'b00;
      afe_reset_o = 1'b0;
      ref_sign_o  = 1'b0;
      busy_o      = (state != IDLE);
      done_o      = (state == DONE);
      case (state)
         RST:     afe_reset_o = 1'b1;
         INT:     afe_sel_o   = 2'b01;
         DEINT: begin
            afe_sel_o  = pol ? 2'b11 : 2'b10;
            ref_sign_o = pol;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dual_slope_seq.sv
// Bench for dual_slope_seq: each scenario is turned into a per-cycle trace of
// expected outputs from phase lengths, and a compare process checks every cycle.
module tb_dual_slope_seq;

   localparam int R  = 2;
   localparam int A  = 4;
   localparam int I  = 8;
   localparam int DM = 20;
   localparam int W  = 8;

   logic         clk_i = 1'b0;
   logic         rst_i, start_i, abort_i;
   logic [2:0]   range_sel_i;
   logic         comp_i, sat_hi_i, sat_lo_i, ref_ok_i;
   logic [1:0]   afe_sel_o;
   logic [2:0]   range_sel_o;
   logic         afe_reset_o, ref_sign_o, busy_o, done_o;
   logic [W-1:0] result_o;
   logic         polarity_o, overrange_o;

   dual_slope_seq #(
      .RST_CYCLES(R), .AZ_CYCLES(A), .INT_CYCLES(I), .DEINT_MAX(DM), .CNT_W(W)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .range_sel_i(range_sel_i), .comp_i(comp_i), .sat_hi_i(sat_hi_i),
      .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i), .afe_sel_o(afe_sel_o),
      .range_sel_o(range_sel_o), .afe_reset_o(afe_reset_o), .ref_sign_o(ref_sign_o),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
      .polarity_o(polarity_o), .overrange_o(overrange_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]   sel;
      logic         rst, sign, busy, done;
      logic [2:0]   rng;
      logic [W-1:0] res;
      logic         pol, ovr;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc;

   // Model of the result-side registers as the spec defines them.
   logic [2:0]   m_rng;
   logic [W-1:0] m_res;
   logic         m_pol, m_ovr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin : cmp
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("afe_sel",     32'(afe_sel_o),   32'(e.sel));
         check("afe_reset",   32'(afe_reset_o), 32'(e.rst));
         check("ref_sign",    32'(ref_sign_o),  32'(e.sign));
         check("busy",        32'(busy_o),      32'(e.busy));
         check("done",        32'(done_o),      32'(e.done));
         check("range_sel",   32'(range_sel_o), 32'(e.rng));
         check("result",      32'(result_o),    32'(e.res));
         check("polarity",    32'(polarity_o),  32'(e.pol));
         check("overrange",   32'(overrange_o), 32'(e.ovr));
      end
   end

   task automatic push(input int n, input logic [1:0] sel, input logic rst,
                       input logic sign, input logic busy, input logic done);
      exp_t e;
      e.sel = sel; e.rst = rst; e.sign = sign; e.busy = busy; e.done = done;
      e.rng = m_rng; e.res = m_res; e.pol = m_pol; e.ovr = m_ovr;
      repeat (n) exp_q.push_back(e);
   endtask

   task automatic push_idle(input int n);
      push(n, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_front_end(input int wait_len, input int az_len, input int int_len);
      push(wait_len, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      push(R,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      push(az_len,   2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      push(int_len,  2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic push_done(input logic [W-1:0] res, input logic pol, input logic ovr);
      m_res = res; m_pol = pol; m_ovr = ovr;
      push(1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      push_idle(3);
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk_i); #1;
         cyc++;
      end
   endtask

   // Leaves the bench one cycle into WAIT_REF with cyc = 0.
   task automatic start_conv(input logic [2:0] rng);
      range_sel_i = rng;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 0;
      m_rng = rng;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk_i);
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk_i); #1;
   endtask

   // Comparator flips to !comp_val during DEINT cycle k (k<0: never).
   task automatic run_normal(input logic [2:0] rng, input logic comp_val, input int k,
                             input bit start_in_deint, input bit toggle_rng);
      int d0, n_deint;
      logic [W-1:0] res;
      logic ovr;
      comp_i = comp_val;
      start_conv(rng);
      // Two sync flops: a flip in DEINT cycle k is seen in DEINT cycle k+2.
      if (k >= 0 && k + 2 <= DM - 1) begin
         n_deint = k + 3; res = W'(k + 2); ovr = 1'b0;
      end else begin
         n_deint = DM; res = W'(DM); ovr = 1'b1;
      end
      push_front_end(1, A, I);
      push(n_deint, comp_val ? 2'b11 : 2'b10, 1'b0, comp_val, 1'b1, 1'b0);
      push_done(res, comp_val, ovr);
      d0 = 1 + R + A + I;
      if (toggle_rng) begin
         goto(3);
         range_sel_i = ~rng;
      end
      if (start_in_deint) begin
         goto(d0);
         start_i = 1'b1;
         goto(d0 + 1);
         start_i = 1'b0;
      end
      if (k >= 0) begin
         goto(d0 + k);
         comp_i = ~comp_val;
      end
      drain();
   endtask

   // Saturation input raised during INT cycle m.
   task automatic run_sat(input logic [2:0] rng, input logic hi, input int m);
      start_conv(rng);
      push_front_end(1, A, m + 3);
      push_done('0, hi, 1'b1);
      goto(1 + R + A + m);
      if (hi) sat_hi_i = 1'b1;
      else    sat_lo_i = 1'b1;
      drain();
      sat_hi_i = 1'b0;
      sat_lo_i = 1'b0;
   endtask

   task automatic run_abort_az(input logic [2:0] rng, input int j);
      start_conv(rng);
      push(1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      push(R, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      push(j + 1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      push_idle(4);
      goto(1 + R + j);
      abort_i = 1'b1;
      goto(1 + R + j + 1);
      abort_i = 1'b0;
      drain();
   endtask

   task automatic run_waitref_then_reset(input logic [2:0] rng);
      int d0;
      ref_ok_i = 1'b0;
      comp_i   = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      start_conv(rng);
      push_front_end(13, A, I);
      push(3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
      m_rng = '0; m_res = '0; m_pol = 1'b0; m_ovr = 1'b0;
      push_idle(3);
      goto(10);
      ref_ok_i = 1'b1;
      d0 = 13 + R + A + I;
      goto(d0 + 2);
      rst_i = 1'b1;
      goto(d0 + 3);
      rst_i = 1'b0;
      drain();
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; range_sel_i = 3'b000;
      comp_i = 1'b1; sat_hi_i = 1'b0; sat_lo_i = 1'b0; ref_ok_i = 1'b1;
      m_rng = '0; m_res = '0; m_pol = 1'b0; m_ovr = 1'b0;

      @(posedge clk_i); #1;
      push_idle(2);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
      push_idle(3);
      drain();

      run_normal(3'b101, 1'b1, 1, 1'b1, 1'b1);
      check("lit_res_crossing", 32'(result_o), 32'd3);
      check("lit_pol_crossing", 32'(polarity_o), 32'd1);
      check("lit_ovr_crossing", 32'(overrange_o), 32'd0);
      check("lit_range_held", 32'(range_sel_o), 32'd5);

      run_normal(3'b010, 1'b0, -1, 1'b0, 1'b0);
      check("lit_res_limit", 32'(result_o), 32'd20);
      check("lit_ovr_limit", 32'(overrange_o), 32'd1);

      run_sat(3'b011, 1'b0, 3);
      check("lit_res_satlo", 32'(result_o), 32'd0);
      check("lit_ovr_satlo", 32'(overrange_o), 32'd1);
      check("lit_pol_satlo", 32'(polarity_o), 32'd0);

      run_normal(3'b001, 1'b1, 17, 1'b0, 1'b0);
      check("lit_res_cross_at_limit", 32'(result_o), 32'd19);
      check("lit_ovr_cross_at_limit", 32'(overrange_o), 32'd0);

      run_normal(3'b111, 1'b0, 18, 1'b0, 1'b0);
      check("lit_res_cross_late", 32'(result_o), 32'd20);

      run_abort_az(3'b110, 2);
      check("lit_abort_busy", 32'(busy_o), 32'd0);
      check("lit_abort_res_kept", 32'(result_o), 32'd20);

      run_sat(3'b100, 1'b1, 0);
      check("lit_pol_sathi", 32'(polarity_o), 32'd1);

      range_sel_i = 3'b000;
      start_i = 1'b1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      push_idle(3);
      drain();
      check("lit_start_abort_range", 32'(range_sel_o), 32'd4);

      run_waitref_then_reset(3'b011);
      check("lit_reset_result", 32'(result_o), 32'd0);

      run_normal(3'b011, 1'b1, 4, 1'b0, 1'b0);
      check("lit_res_after_reset", 32'(result_o), 32'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
